// File: rtl/rf_alu_wb_pkg.sv
// rf_alu_wb_pkg: FSM states, 4-bit ALU-control codes and LEGv8 opcode constants
package rf_alu_wb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_NOR   = 11'b11101010000;
  localparam logic [10:0] OP_PASSB = 11'b11111000010;
endpackage

// File: rtl/rf_alu_wb_if.sv
// rf_alu_wb_if: host write, operation request and status bundle for rf_alu_wb
interface rf_alu_wb_if #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [WIDTH-1:0]  WriteData;
  logic              start;
  logic [ADDR_W-1:0] Read1;
  logic [ADDR_W-1:0] Read2;
  logic [ADDR_W-1:0] Dest;
  logic [1:0]        ALUOp;
  logic [10:0]       OpcodeField;
  logic              busy;
  logic              done;
  logic              wr_reject;
  logic              illegal_op;
  logic [WIDTH-1:0]  ALU_Result;
  logic              zero;
  modport master (
    output RegWrite, WriteReg, WriteData, start, Read1, Read2, Dest, ALUOp, OpcodeField,
    input  busy, done, wr_reject, illegal_op, ALU_Result, zero
  );
  modport slave (
    input  RegWrite, WriteReg, WriteData, start, Read1, Read2, Dest, ALUOp, OpcodeField,
    output busy, done, wr_reject, illegal_op, ALU_Result, zero
  );
endinterface

// File: rtl/rf_alu_wb_core.sv
// rf_alu_wb_core: LEGv8 ALU-control decode and combinational ALU
module rf_alu_wb_core
  import rf_alu_wb_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] alu;
  always_comb begin
    illegal = 1'b0;
    ctrl = ALU_ADD;
    if (alu_op == 2'b01) ctrl = ALU_PASSB;
    else if (alu_op[1])
      case (opcode)
        OP_AND:   ctrl = ALU_AND;
        OP_ORR:   ctrl = ALU_OR;
        OP_ADD:   ctrl = ALU_ADD;
        OP_SUB:   ctrl = ALU_SUB;
        OP_NOR:   ctrl = ALU_NOR;
        OP_PASSB: ctrl = ALU_PASSB;
        default:  illegal = 1'b1;
      endcase
  end
  always_comb begin
    alu = '0;
    case (ctrl)
      ALU_AND:   alu = a & b;
      ALU_OR:    alu = a | b;
      ALU_ADD:   alu = a + b;
      ALU_SUB:   alu = a - b;
      ALU_PASSB: alu = b;
      ALU_NOR:   alu = ~(a | b);
      default:   alu = '0;
    endcase
  end
  assign result = illegal ? '0 : alu;
endmodule

// File: rtl/rf_alu_wb.sv
// rf_alu_wb: register file with a four-state READ/EXEC/WB ALU sequencer
// Define RF_ALU_WB_XZR_EN to hard-wire register NUM_REGS-1 to zero.
module rf_alu_wb
  import rf_alu_wb_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32
) (
  input logic        clock,
  input logic        reset,
  rf_alu_wb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] READ = S_READ;
  localparam logic [1:0] EXEC = S_EXEC;
  localparam logic [1:0] WB   = S_WB;
  localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);
`ifdef RF_ALU_WB_XZR_EN
  localparam logic XZR_EN = 1'b1;
`else
  localparam logic XZR_EN = 1'b0;
`endif
  logic [1:0]        state, state_n;
  logic [WIDTH-1:0]  regs [NUM_REGS];
  logic [WIDTH-1:0]  a_q, b_q, res, res_q;
  logic [ADDR_W-1:0] r1_q, r2_q, dest_q;
  logic [1:0]        op_q;
  logic [10:0]       opc_q;
  logic              ill, zero_q, done_q, rej_q, ill_q, host_wr, wb_wr;
  rf_alu_wb_core #(.WIDTH(WIDTH)) core (
    .alu_op(op_q), .opcode(opc_q), .a(a_q), .b(b_q), .result(res), .illegal(ill)
  );
  always_comb
    state_n = state == IDLE ? (bus.start ? READ : IDLE) :
              state == READ ? EXEC :
              state == EXEC ? WB : IDLE;
  assign host_wr = bus.RegWrite && state == IDLE && !(XZR_EN && bus.WriteReg == XZR);
  // ill_q is the registered illegal flag, so it is high exactly during WB of a bad op
  assign wb_wr = state == WB && !ill_q && !(XZR_EN && dest_q == XZR);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_wr) regs[bus.WriteReg] <= bus.WriteData;
      if (wb_wr) regs[dest_q] <= res_q;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= IDLE;
      r1_q   <= '0;
      r2_q   <= '0;
      dest_q <= '0;
      op_q   <= '0;
      opc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
      rej_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= state == WB;
      rej_q  <= bus.RegWrite && state != IDLE;
      ill_q  <= state == EXEC && ill;
      if (state == IDLE && bus.start) begin
        r1_q   <= bus.Read1;
        r2_q   <= bus.Read2;
        dest_q <= bus.Dest;
        op_q   <= bus.ALUOp;
        opc_q  <= bus.OpcodeField;
      end
      if (state == READ) begin
        a_q <= (XZR_EN && r1_q == XZR) ? '0 : regs[r1_q];
        b_q <= (XZR_EN && r2_q == XZR) ? '0 : regs[r2_q];
      end
      if (state == EXEC) begin
        res_q  <= res;
        zero_q <= res == '0;
      end
    end
  assign bus.busy       = state != IDLE;
  assign bus.done       = done_q;
  assign bus.wr_reject  = rej_q;
  assign bus.illegal_op = ill_q;
  assign bus.ALU_Result = res_q;
  assign bus.zero       = zero_q;
endmodule

// File: tb/tb_rf_alu_wb.sv
// tb_rf_alu_wb: randomized self-checking bench for rf_alu_wb against a behavioural model
module tb_rf_alu_wb;
  localparam logic [10:0] C_AND = 11'b10001010000;
  localparam logic [10:0] C_ORR = 11'b10101010000;
  localparam logic [10:0] C_ADD = 11'b10001011000;
  localparam logic [10:0] C_SUB = 11'b11001011000;
  localparam logic [10:0] C_NOR = 11'b11101010000;
  localparam logic [10:0] C_PSB = 11'b11111000010;
  localparam logic [63:0] P5 = 64'h5555555555555555;
  localparam logic [63:0] PA = 64'hAAAAAAAAAAAAAAAA;
  logic clock = 1'b0;
  logic reset;
  logic [63:0] m_rf [32];
  logic [10:0] legal [6];
  int n_chk = 0;
  int n_err = 0;
  rf_alu_wb_if #(.WIDTH(64), .NUM_REGS(32)) bus ();
  rf_alu_wb #(.WIDTH(64), .NUM_REGS(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] m_rd(input logic [4:0] r);
`ifdef RF_ALU_WB_XZR_EN
    if (r == 5'd31) return 64'h0;
`endif
    return m_rf[r];
  endfunction
  task automatic m_wr(input logic [4:0] r, input logic [63:0] d);
`ifdef RF_ALU_WB_XZR_EN
    if (r == 5'd31) return;
`endif
    m_rf[r] = d;
  endtask
  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [10:0] opc,
                                          input logic [63:0] a, input logic [63:0] b, output logic ill);
    ill = 1'b0;
    ref_alu = 64'h0;
    if (op == 2'b00) ref_alu = a + b;
    else if (op == 2'b01) ref_alu = b;
    else if (opc == C_AND) ref_alu = a & b;
    else if (opc == C_ORR) ref_alu = a | b;
    else if (opc == C_ADD) ref_alu = a + b;
    else if (opc == C_SUB) ref_alu = a - b;
    else if (opc == C_NOR) ref_alu = ~(a | b);
    else if (opc == C_PSB) ref_alu = b;
    else ill = 1'b1;
  endfunction
  task automatic host_write(input logic [4:0] r, input logic [63:0] d);
    @(negedge clock);
    bus.RegWrite = 1'b1;
    bus.WriteReg = r;
    bus.WriteData = d;
    @(negedge clock);
    bus.RegWrite = 1'b0;
    chk("hw_no_reject", bus.wr_reject, 1'b0);
    m_wr(r, d);
  endtask
  task automatic do_op(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic [1:0] op, input logic [10:0] opc, input logic hw, input logic [63:0] hd);
    logic [63:0] exp;
    logic ill;
    if (hw) m_wr(r1, hd);
    exp = ref_alu(op, opc, m_rd(r1), m_rd(r2), ill);
    @(negedge clock);
    bus.start = 1'b1;
    bus.Read1 = r1;
    bus.Read2 = r2;
    bus.Dest = d;
    bus.ALUOp = op;
    bus.OpcodeField = opc;
    bus.RegWrite = hw;
    bus.WriteReg = r1;
    bus.WriteData = hd;
    @(negedge clock);
    bus.start = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Read1 = 5'($urandom);
    bus.Read2 = 5'($urandom);
    bus.Dest = 5'($urandom);
    bus.ALUOp = 2'($urandom);
    bus.OpcodeField = 11'($urandom);
    chk("busy_read", bus.busy, 1'b1);
    chk("done_early1", bus.done, 1'b0);
    @(negedge clock);
    chk("done_early2", bus.done, 1'b0);
    @(negedge clock);
    chk("illegal_op", bus.illegal_op, ill);
    chk("result", bus.ALU_Result, exp);
    chk("zero", bus.zero, exp == 64'h0);
    chk("done_early3", bus.done, 1'b0);
    @(negedge clock);
    chk("done_at_3", bus.done, 1'b1);
    chk("busy_idle", bus.busy, 1'b0);
    chk("illegal_clear", bus.illegal_op, 1'b0);
    if (!ill) m_wr(d, exp);
  endtask
  task automatic rdback(input logic [4:0] r);
    do_op(5'd0, r, 5'd30, 2'b01, 11'd0, 1'b0, 64'h0);
  endtask
  task automatic chk_outs_zero(input string tag);
    chk({tag, "_res"}, bus.ALU_Result, 64'h0);
    chk({tag, "_zero"}, bus.zero, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_rej"}, bus.wr_reject, 1'b0);
    chk({tag, "_ill"}, bus.illegal_op, 1'b0);
  endtask
  initial begin
    legal = '{C_AND, C_ORR, C_ADD, C_SUB, C_NOR, C_PSB};
    for (int i = 0; i < 32; i++) m_rf[i] = 64'h0;
    reset = 1'b1;
    bus.RegWrite = 1'b0;
    bus.WriteReg = '0;
    bus.WriteData = '0;
    bus.start = 1'b0;
    bus.Read1 = '0;
    bus.Read2 = '0;
    bus.Dest = '0;
    bus.ALUOp = '0;
    bus.OpcodeField = '0;
    repeat (2) @(negedge clock);
    chk_outs_zero("rst");
    reset = 1'b0;
    host_write(5'd5, P5);
    host_write(5'd10, PA);
    do_op(5'd5, 5'd10, 5'd20, 2'b10, C_AND, 1'b0, 64'h0);
    chk("and_val", bus.ALU_Result, 64'h0);
    chk("and_zero", bus.zero, 1'b1);
    do_op(5'd5, 5'd10, 5'd20, 2'b10, C_ORR, 1'b0, 64'h0);
    chk("orr_val", bus.ALU_Result, 64'hFFFFFFFFFFFFFFFF);
    do_op(5'd5, 5'd10, 5'd20, 2'b10, C_ADD, 1'b0, 64'h0);
    chk("add_val", bus.ALU_Result, 64'hFFFFFFFFFFFFFFFF);
    do_op(5'd5, 5'd10, 5'd20, 2'b10, C_SUB, 1'b0, 64'h0);
    chk("sub_val", bus.ALU_Result, 64'hAAAAAAAAAAAAAAAB);
    do_op(5'd5, 5'd10, 5'd20, 2'b10, C_NOR, 1'b0, 64'h0);
    chk("nor_val", bus.ALU_Result, 64'h0);
    do_op(5'd5, 5'd10, 5'd1, 2'b10, C_ORR, 1'b0, 64'h0);
    do_op(5'd1, 5'd5, 5'd2, 2'b10, C_AND, 1'b0, 64'h0);
    rdback(5'd2);
    chk("chain_r2", bus.ALU_Result, P5);
    @(negedge clock);
    bus.start = 1'b1;
    bus.Read1 = 5'd5;
    bus.Read2 = 5'd10;
    bus.Dest = 5'd3;
    bus.ALUOp = 2'b10;
    bus.OpcodeField = C_ORR;
    @(negedge clock);
    chk("busy_ign", bus.busy, 1'b1);
    bus.RegWrite = 1'b1;
    bus.WriteReg = 5'd7;
    bus.WriteData = 64'hDEADBEEFCAFEF00D;
    bus.Dest = 5'd4;
    bus.OpcodeField = C_AND;
    @(negedge clock);
    chk("rej_pulse", bus.wr_reject, 1'b1);
    bus.RegWrite = 1'b0;
    @(negedge clock);
    chk("rej_once", bus.wr_reject, 1'b0);
    @(negedge clock);
    chk("busy_done", bus.done, 1'b1);
    bus.start = 1'b0;
    @(negedge clock);
    chk("no_queue_busy", bus.busy, 1'b0);
    chk("no_queue_done", bus.done, 1'b0);
    m_wr(5'd3, P5 | PA);
    rdback(5'd7);
    chk("rej_r7", bus.ALU_Result, 64'h0);
    rdback(5'd3);
    rdback(5'd4);
    do_op(5'd5, 5'd10, 5'd2, 2'b10, 11'd0, 1'b0, 64'h0);
    rdback(5'd2);
    chk("ill_dest", bus.ALU_Result, P5);
    @(negedge clock);
    bus.start = 1'b1;
    bus.Read1 = 5'd5;
    bus.Read2 = 5'd10;
    bus.Dest = 5'd9;
    bus.ALUOp = 2'b00;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_outs_zero("abort");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_done", bus.done, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 64'h0;
    rdback(5'd9);
    chk("abort_r9", bus.ALU_Result, 64'h0);
    rdback(5'd5);
    chk("abort_r5", bus.ALU_Result, 64'h0);
    host_write(5'd5, 64'h1234);
    host_write(5'd6, 64'h1);
    do_op(5'd5, 5'd6, 5'd31, 2'b00, 11'd0, 1'b0, 64'h0);
    rdback(5'd31);
`ifdef RF_ALU_WB_XZR_EN
    chk("xzr_val", bus.ALU_Result, 64'h0);
    chk("xzr_zero", bus.zero, 1'b1);
`else
    chk("r31_val", bus.ALU_Result, 64'h1235);
`endif
    do_op(5'd5, 5'd5, 5'd8, 2'b10, C_SUB, 1'b1, 64'h0F0F);
    chk("coincide", bus.ALU_Result, 64'h0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        host_write(5'($urandom), {$urandom, $urandom});
      else
        do_op(5'($urandom), ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom), 5'($urandom),
              2'($urandom), ($urandom_range(0, 5) == 0) ? 11'($urandom) : legal[$urandom_range(0, 5)],
              $urandom_range(0, 5) == 0, {$urandom, $urandom});
    end
    for (int r = 0; r < 32; r++) begin
      rdback(5'(r));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
